redmule_tcdm_sync: RTL
======================

// Module: redmule_tcdm_sync
// PURPOSE
// - Sits between the RedMulE streamer's wide HCI master port and the MP 32-bit TCDM ports.
// - Splits each wide request into MP word requests and tracks grants per port, so staggered grants are safe.
// - Collects per-port read/write responses and returns one aligned wide response.
// - The downstream wrapper no longer needs to AND the grants or the r_valid signals together.
// PARAMETERS
// - DW    default DATA_W     wide data width in bits; multiple of 32
// - MP    default DW/32      number of 32-bit TCDM ports
// PORTS
// - clk_i           in   1         clock
// - rst_ni          in   1         asynchronous active-low reset
// - wide_req_i      in   1         wide request; held stable until wide_gnt_o
// - wide_gnt_o      out  1         wide request accepted
// - wide_add_i      in   32        byte address, word-aligned; port i uses add+4*i
// - wide_wen_i      in   1         1=read, 0=write
// - wide_be_i       in   DW/8      byte enables; port i gets bits [4i+3:4i]
// - wide_data_i     in   DW        write data; port i gets bits [32i+31:32i]
// - wide_r_data_o   out  DW        assembled response data
// - wide_r_valid_o  out  1         assembled response valid
// - tcdm_req_o      out  MP        per-port request
// - tcdm_gnt_i      in   MP        per-port grant
// - tcdm_add_o      out  MPx32     per-port address
// - tcdm_wen_o      out  MP        per-port wen
// - tcdm_be_o       out  MPx4      per-port byte enables
// - tcdm_data_o     out  MPx32     per-port write data
// - tcdm_r_data_i   in   MPx32     per-port response data
// - tcdm_r_valid_i  in   MP        per-port response valid
// BEHAVIOUR
// - Reset value of every output is 0; all state registers clear to 0.
// - Per-port state:
//   - gnt_q[i]: port i has been granted for the current wide request.
//   - pend_q[i]: granted, response not yet seen.
//   - rsp_q[i]: response buffered, with data buffer rdat_q[i].
// - Response side:
//   - rsp_here[i] = rsp_q[i] | tcdm_r_valid_i[i].
//   - done = |(rsp_q|pend_q) & &(rsp_here | ~(rsp_q|pend_q) & ...). Simplified rule: done = (rsp_q|pend_q) nonzero and every port has rsp_here.
//   - wide_r_valid_o = done. This is combinational: zero added latency when all ports respond in the same cycle.
//   - wide_r_data_o[i] = rsp_q[i] ? rdat_q[i] : tcdm_r_data_i[i].
//   - On done: rsp_q and pend_q clear, except for newly granted ports, which set pend_q.
// - Request side:
//   - free[i] = ~(pend_q[i] | rsp_q[i]) | done.
//   - tcdm_req_o[i] = wide_req_i & ~gnt_q[i] & free[i].
//   - wide_gnt_o = wide_req_i & &(gnt_q | (tcdm_req_o & tcdm_gnt_i)).
//   - On wide_gnt_o: gnt_q clears. Otherwise gnt_q |= tcdm_req_o & tcdm_gnt_i.
// - Each port has at most one transaction awaiting collection, so responses can never be reordered.
// - With fixed 1-cycle TCDM latency and all grants aligned, the block sustains 1 wide request per cycle.
// - Both reads and writes produce a response; r_valid is expected for every granted word.
// - If tcdm_r_valid_i[i] arrives while pend_q[i]=0, the response is ignored. This is a protocol error, and a simulation assertion fires.
// - Dropping wide_req_i before wide_gnt_o is illegal; gnt_q is kept as-is.
// - An asynchronous reset mid-transaction drops all in-flight state.
// CONFIGURATION
// - Macro REDMULE_TCDM_SYNC_PERF_EN.
// - When defined, adds these ports:
//   - perf_clr_i  in  1
//   - perf_stall_o  out  32: counts cycles with wide_req_i & ~wide_gnt_o, saturating at 32'hFFFF_FFFF.
//   - perf_clr_i zeroes the counter on the next edge; clear wins over increment.
// - When undefined, these ports and the counter are absent, and the rest of the behaviour is identical.
// STRUCTURE
// - redmule_pkg gets:
//   - TCDM_WORD_W = 32
//   - typedef tcdm_word_t (logic [31:0])
//   - typedef tcdm_be_t (logic [3:0])
// - Sub-module redmule_tcdm_rsp_collect holds pend_q/rsp_q/rdat_q and the done logic. It is instantiated once, vectorised over MP.
// TESTING
// - Aligned grants: all tcdm_gnt_i=1, 1-cycle r_valid, 4 back-to-back reads at add 0x100 -> 4 wide_gnt_o on consecutive cycles; 4 wide_r_valid_o with word i = mem[0x100+4i].
// - Staggered grants: MP=4, port 2 grant 3 cycles late -> wide_gnt_o only in the cycle port 2 is granted; ports 0,1,3 do not re-request; data is assembled correctly.
// - Staggered responses: port 0 r_valid 2 cycles after the others -> exactly one wide_r_valid_o in port 0's response cycle; buffered words intact.
// - Write then read to the same address with be=all ones, data 0xA5A5... -> the read returns 0xA5A5...; exactly 2 wide_r_valid_o.
// - Reset asserted while pend_q!=0 -> all outputs 0 asynchronously; after release a new read completes normally.
// - PERF_EN: hold tcdm_gnt_i=0 for 5 cycles with wide_req_i=1 -> perf_stall_o=5; pulse perf_clr_i -> 0.

Source files
------------

// File: rtl/redmule_pkg.sv
// Shared types and constants for the RedMulE TCDM synchroniser slice.
package redmule_pkg;

    localparam int unsigned TCDM_WORD_W = 32;
    localparam int unsigned DATA_W      = 128;

    typedef logic [TCDM_WORD_W-1:0] tcdm_word_t;
    typedef logic [3:0]             tcdm_be_t;

endpackage

// File: rtl/redmule_tcdm_rsp_collect.sv
// Per-port response collector: tracks outstanding words, buffers early
// responses and signals when a complete wide response can be returned.
module redmule_tcdm_rsp_collect
    import redmule_pkg::*;
#(
    parameter int unsigned MP = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [MP-1:0]       new_gnt,
    input  logic [MP-1:0]       r_valid,
    input  tcdm_word_t [MP-1:0] r_data,
    output logic [MP-1:0]       busy,
    output logic                done,
    output tcdm_word_t [MP-1:0] rsp_data
);

    logic [MP-1:0]       pend_q;
    logic [MP-1:0]       rsp_q;
    logic [MP-1:0]       rsp_here;
    tcdm_word_t [MP-1:0] rdat_q;

    // A response only counts for a port that is actually waiting for one.
    assign rsp_here = rsp_q | (pend_q & r_valid);
    assign busy     = pend_q | rsp_q;
    assign done     = (|busy) & (&rsp_here);

    // Merge buffered words with words arriving this cycle; zero when idle.
    always_comb begin
        rsp_data = '0;
        for (int i = 0; i < MP; i++) begin
            if (done) begin
                rsp_data[i] = rsp_q[i] ? rdat_q[i] : r_data[i];
            end
        end
    end

    // Track outstanding words and capture responses that arrive early.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            rsp_q  <= '0;
            rdat_q <= '0;
        end else if (done) begin
            pend_q <= new_gnt;
            rsp_q  <= '0;
        end else begin
            pend_q <= (pend_q & ~r_valid) | new_gnt;
            rsp_q  <= rsp_q | (pend_q & r_valid);
            for (int i = 0; i < MP; i++) begin
                if (pend_q[i] && r_valid[i]) begin
                    rdat_q[i] <= r_data[i];
                end
            end
        end
    end

    stray_rsp_check : assert property (
        @(posedge clk) disable iff (!rst_n) ((r_valid & ~pend_q) == '0)
    );

endmodule

// File: rtl/redmule_tcdm_sync.sv
// Splits a wide HCI request into MP word requests with per-port grant
// tracking and reassembles one aligned wide response.
// Optional stall counter enabled by defining REDMULE_TCDM_SYNC_PERF_EN.
module redmule_tcdm_sync
    import redmule_pkg::*;
#(
    parameter int unsigned DW = DATA_W,
    parameter int unsigned MP = DW / 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wide_req_i,
    output logic                wide_gnt_o,
    input  logic [31:0]         wide_add_i,
    input  logic                wide_wen_i,
    input  logic [DW/8-1:0]     wide_be_i,
    input  logic [DW-1:0]       wide_data_i,
    output logic [DW-1:0]       wide_r_data_o,
    output logic                wide_r_valid_o,
    output logic [MP-1:0]       tcdm_req_o,
    input  logic [MP-1:0]       tcdm_gnt_i,
    output tcdm_word_t [MP-1:0] tcdm_add_o,
    output logic [MP-1:0]       tcdm_wen_o,
    output tcdm_be_t [MP-1:0]   tcdm_be_o,
    output tcdm_word_t [MP-1:0] tcdm_data_o,
    input  tcdm_word_t [MP-1:0] tcdm_r_data_i,
    input  logic [MP-1:0]       tcdm_r_valid_i
`ifdef REDMULE_TCDM_SYNC_PERF_EN
    ,
    input  logic                perf_clr_i,
    output logic [31:0]         perf_stall_o
`endif
);

    logic                req_live;
    logic [MP-1:0]       gnt_q;
    logic [MP-1:0]       busy;
    logic [MP-1:0]       free;
    logic [MP-1:0]       new_gnt;
    logic                done;
    tcdm_word_t [MP-1:0] rsp_data;

    // Outputs must read zero while reset is held, even with a request pending.
    assign req_live   = wide_req_i & rst_ni;
    assign free       = ~busy | {MP{done}};
    assign tcdm_req_o = {MP{req_live}} & ~gnt_q & free;
    assign new_gnt    = tcdm_req_o & tcdm_gnt_i;
    assign wide_gnt_o = req_live & (&(gnt_q | new_gnt));

    // Slice the wide request into per-port words; payload is zero when a port is not requesting.
    always_comb begin
        tcdm_add_o  = '0;
        tcdm_wen_o  = '0;
        tcdm_be_o   = '0;
        tcdm_data_o = '0;
        for (int i = 0; i < MP; i++) begin
            if (tcdm_req_o[i]) begin
                tcdm_add_o[i]  = wide_add_i + 32'(4 * i);
                tcdm_wen_o[i]  = wide_wen_i;
                tcdm_be_o[i]   = wide_be_i[4*i +: 4];
                tcdm_data_o[i] = wide_data_i[32*i +: 32];
            end
        end
    end

    // Remember which ports already accepted the current wide request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q <= '0;
        end else if (wide_gnt_o) begin
            gnt_q <= '0;
        end else begin
            gnt_q <= gnt_q | new_gnt;
        end
    end

    redmule_tcdm_rsp_collect #(
        .MP (MP)
    ) i_rsp_collect (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .new_gnt  (new_gnt),
        .r_valid  (tcdm_r_valid_i),
        .r_data   (tcdm_r_data_i),
        .busy     (busy),
        .done     (done),
        .rsp_data (rsp_data)
    );

    assign wide_r_valid_o = done;
    assign wide_r_data_o  = rsp_data;

`ifdef REDMULE_TCDM_SYNC_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of cycles a wide request waits for its grant; clear has priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (perf_clr_i) begin
            stall_q <= '0;
        end else if (wide_req_i && !wide_gnt_o && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_stall_o = stall_q;
`endif

endmodule
